// File: rtl/dht22_pkg.sv
// Shared types and protocol constants for the DHT22 frame receiver.
// Times are in microseconds and scaled to clock ticks by the users.
package dht22_pkg;

  localparam int START_LOW_US      = 1000;
  localparam int TIMEOUT_US        = 200;
  localparam int BIT_ONE_THRESH_US = 50;
  localparam int FRAME_BITS        = 40;

  typedef enum logic [3:0] {
    IDLE,
    START_LOW,
    WAIT_RESP,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    DONE,
    ERROR
  } dht22_rx_state_t;

  typedef struct packed {
    logic [7:0] hum_hi;
    logic [7:0] hum_lo;
    logic [7:0] temp_hi;
    logic [7:0] temp_lo;
    logic [7:0] checksum;
  } dht22_frame_t;

  function automatic logic crc_check(dht22_frame_t f);
    logic [7:0] s;
    s = f.hum_hi + f.hum_lo + f.temp_hi + f.temp_lo;
    return s == f.checksum;
  endfunction

endpackage

// File: rtl/dht22_frame_rx_if.sv
// Request/result bundle between the trigger logic and the DHT22 receiver.
// master = requester, slave = dht22_frame_rx.
interface dht22_frame_rx_if;
  import dht22_pkg::*;

  logic         start_read;
  logic         busy;
  dht22_frame_t frame;
  logic         crc_ok;
  logic         frame_valid;
  logic         timeout_err;

  modport master (
    output start_read,
    input  busy, frame, crc_ok,
    input  frame_valid, timeout_err
  );

  modport slave (
    input  start_read,
    output busy, frame, crc_ok,
    output frame_valid, timeout_err
  );

endinterface

// File: rtl/dht22_line_sync.sv
// 2-FF synchronizer plus edge detect for the DHT22 data line.
// DHT22_GLITCH_FILTER_EN adds a 4-sample agreement filter (+3 cycles).
module dht22_line_sync (
  input  logic clk,
  input  logic arstn,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk) begin
    if (!arstn) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= pad;
      s2   <= s1;
      prev <= level;
    end
  end

`ifdef DHT22_GLITCH_FILTER_EN
  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (!arstn) sh <= 3'b111;
    else        sh <= {sh[1:0], s2};
  end

  // prev holds the accepted level until four samples agree
  always_comb begin
    level = prev;
    if (s2 == sh[0] && s2 == sh[1] && s2 == sh[2])
      level = s2;
  end
`else
  always_comb level = s2;
`endif

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/dht22_frame_rx.sv
// DHT22 single-wire protocol engine: start pulse, handshake, 40-bit frame.
// Optional DHT22_GLITCH_FILTER_EN is handled inside dht22_line_sync.
module dht22_frame_rx
  import dht22_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic arstn,
  inout  wire  dht22_in_out,
  dht22_frame_rx_if.slave bus
);

  localparam int TICKS_PER_US = CLK_FREQ / 1_000_000;
  localparam int TW = $clog2(START_LOW_US * TICKS_PER_US + 1);

  localparam logic [TW-1:0] START_T =
    TW'(START_LOW_US * TICKS_PER_US - 1);
  localparam logic [TW-1:0] TOUT_T =
    TW'(TIMEOUT_US * TICKS_PER_US - 1);
  localparam logic [TW-1:0] ONE_T =
    TW'(BIT_ONE_THRESH_US * TICKS_PER_US - 1);
  localparam logic [TW-1:0] T_MAX = '1;

  dht22_rx_state_t       state;
  logic [TW-1:0]         timer;
  logic [5:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  drive_low;
  logic                  tmo;
  logic                  line_level;
  logic                  unused_level;
  logic                  rise;
  logic                  fall;

  assign dht22_in_out = drive_low ? 1'b0 : 1'bz;

  dht22_line_sync u_sync (
    .clk   (clk),
    .arstn (arstn),
    .pad   (dht22_in_out),
    .level (line_level),
    .rise  (rise),
    .fall  (fall)
  );

  assign unused_level = line_level;
  assign tmo = timer >= TOUT_T;

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state           <= IDLE;
      timer           <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      drive_low       <= 1'b0;
      bus.busy        <= 1'b0;
      bus.frame       <= '0;
      bus.crc_ok      <= 1'b0;
      bus.frame_valid <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.frame_valid <= 1'b0;
      bus.timeout_err <= 1'b0;
      timer <= (timer == T_MAX) ? timer : timer + 1'b1;
      unique case (state)
        IDLE: begin
          // a request landing on the result pulse is dropped
          if (bus.start_read && !bus.frame_valid &&
              !bus.timeout_err) begin
            state     <= START_LOW;
            timer     <= '0;
            bit_cnt   <= '0;
            drive_low <= 1'b1;
            bus.busy  <= 1'b1;
          end
        end
        START_LOW: begin
          if (timer == START_T) begin
            state     <= WAIT_RESP;
            timer     <= '0;
            drive_low <= 1'b0;
          end
        end
        WAIT_RESP: begin
          if (tmo) begin
            state <= ERROR;
            timer <= '0;
          end else if (fall) begin
            state <= RESP_LOW;
            timer <= '0;
          end
        end
        RESP_LOW: begin
          if (tmo) begin
            state <= ERROR;
            timer <= '0;
          end else if (rise) begin
            state <= RESP_HIGH;
            timer <= '0;
          end
        end
        RESP_HIGH: begin
          if (tmo) begin
            state <= ERROR;
            timer <= '0;
          end else if (fall) begin
            state <= BIT_LOW;
            timer <= '0;
          end
        end
        BIT_LOW: begin
          if (tmo) begin
            state <= ERROR;
            timer <= '0;
          end else if (rise) begin
            state <= BIT_HIGH;
            timer <= '0;
          end
        end
        BIT_HIGH: begin
          if (tmo) begin
            state <= ERROR;
            timer <= '0;
          end else if (fall) begin
            // timer started one cycle after rise, so it lags width by 1
            shreg   <= {shreg[FRAME_BITS-2:0], timer >= ONE_T};
            bit_cnt <= bit_cnt + 6'd1;
            timer   <= '0;
            state   <= (bit_cnt == 6'(FRAME_BITS - 1)) ? DONE : BIT_LOW;
          end
        end
        DONE: begin
          bus.frame       <= shreg;
          bus.crc_ok      <= crc_check(dht22_frame_t'(shreg));
          bus.frame_valid <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= IDLE;
          timer           <= '0;
        end
        ERROR: begin
          bus.timeout_err <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= IDLE;
          timer           <= '0;
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht22_frame_rx.sv
// Randomized bench for dht22_frame_rx with a behavioural DHT22 sensor.
// Runs at 1 MHz so one microsecond is one clock.
module tb_dht22_frame_rx;

`ifdef DHT22_GLITCH_FILTER_EN
  localparam int SYNC_LAT = 5;
`else
  localparam int SYNC_LAT = 2;
`endif

  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic sens_low = 1'b0;
  wire  dht;

  always #5 clk = ~clk;

  assign dht = sens_low ? 1'b0 : 1'bz;
  pullup (dht);

  dht22_frame_rx_if bus ();

  dht22_frame_rx #(.CLK_FREQ(1_000_000)) dut (
    .clk          (clk),
    .arstn        (arstn),
    .dht22_in_out (dht),
    .bus          (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int to_cnt = 0;
  int both_cnt = 0;
  int host_starts = 0;
  int fv_cyc = 0;
  int to_cyc = 0;
  int fall_cyc = 0;
  int rel_cyc = 0;
  logic host_low_prev = 1'b0;
  logic host_low_now;
  int hi_w [40];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.frame_valid) begin
      fv_cnt = fv_cnt + 1;
      fv_cyc = cyc;
    end
    if (bus.timeout_err) begin
      to_cnt = to_cnt + 1;
      to_cyc = cyc;
    end
    if (bus.frame_valid && bus.timeout_err)
      both_cnt = both_cnt + 1;
    host_low_now = (dht === 1'b0) && !sens_low;
    if (host_low_now && !host_low_prev)
      host_starts = host_starts + 1;
    host_low_prev = host_low_now;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycles %0d required < 95000", cyc);
    $fatal(1, "cycle budget exhausted");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_widths(input logic [39:0] f, input bit std);
    for (int i = 0; i < 40; i++) begin
      if (std)
        hi_w[i] = f[39-i] ? 70 : 26;
      else if (f[39-i])
        hi_w[i] = int'($urandom_range(85, 50));
      else
        hi_w[i] = int'($urandom_range(49, 15));
    end
  endtask

  // rst_mode 1: reset in start pulse, 2: reset at bit 20
  task automatic sensor(input bit present, input int inj,
                        input int rst_mode);
    int n;
    n = 0;
    while (dht !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    chk("req_to_low", 64'(n), 64'd0);
    n = 0;
    while (dht === 1'b0 && n < 3000) begin
      if (inj == 1 && n == 500) bus.start_read = 1'b1;
      if (inj == 1 && n == 501) bus.start_read = 1'b0;
      if (rst_mode == 1 && n == 300) begin
        arstn = 1'b0;
        tick();
        chk("rst_sl_line", 64'(dht), 64'd1);
        chk("rst_sl_busy", 64'(bus.busy), 64'd0);
        arstn = 1'b1;
        tick();
        return;
      end
      tick();
      n++;
    end
    chk("start_len", 64'(n), 64'd1000);
    rel_cyc = cyc;
    if (!present) return;
    repeat (30) tick();
    sens_low = 1'b1;
    repeat (80) tick();
    sens_low = 1'b0;
    repeat (80) tick();
    for (int i = 0; i < 40; i++) begin
      sens_low = 1'b1;
      if (rst_mode == 2 && i == 20) begin
        repeat (5) tick();
        arstn = 1'b0;
        tick();
        chk("rst20_busy", 64'(bus.busy), 64'd0);
        chk("rst20_frame", 64'(bus.frame), 64'd0);
        chk("rst20_crc", 64'(bus.crc_ok), 64'd0);
        chk("rst20_fv", 64'(bus.frame_valid), 64'd0);
        chk("rst20_to", 64'(bus.timeout_err), 64'd0);
        arstn = 1'b1;
        sens_low = 1'b0;
        repeat (20) tick();
        return;
      end
      if (inj == 2 && i == 10) begin
        bus.start_read = 1'b1;
        tick();
        bus.start_read = 1'b0;
        repeat (29) tick();
      end else begin
        repeat (30) tick();
      end
      sens_low = 1'b0;
      repeat (hi_w[i]) tick();
    end
    sens_low = 1'b1;
    fall_cyc = cyc;
    if (inj == 3) begin
      repeat (SYNC_LAT + 2) tick();
      bus.start_read = 1'b1;
      tick();
      bus.start_read = 1'b0;
      repeat (50 - SYNC_LAT - 3) tick();
    end else begin
      repeat (50) tick();
    end
    sens_low = 1'b0;
    repeat (20) tick();
  endtask

  task automatic txn(input int inj, input string tag);
    int fv0, to0, hs0, s;
    logic [39:0] ef;
    logic ec;
    fv0 = fv_cnt;
    to0 = to_cnt;
    hs0 = host_starts;
    for (int i = 0; i < 40; i++) ef[39-i] = hi_w[i] >= 50;
    s = int'(ef[39:32]) + int'(ef[31:24]) + int'(ef[23:16])
      + int'(ef[15:8]);
    ec = (s % 256) == int'(ef[7:0]);
    bus.start_read = 1'b1;
    tick();
    bus.start_read = 1'b0;
    chk({tag, "_busy_hi"}, 64'(bus.busy), 64'd1);
    sensor(1'b1, inj, 0);
    chk({tag, "_fv_cnt"}, 64'(fv_cnt - fv0), 64'd1);
    chk({tag, "_to_cnt"}, 64'(to_cnt - to0), 64'd0);
    chk({tag, "_starts"}, 64'(host_starts - hs0), 64'd1);
    chk({tag, "_frame"}, 64'(bus.frame), 64'(ef));
    chk({tag, "_crc"}, 64'(bus.crc_ok), 64'(ec));
    chk({tag, "_fv_lat"}, 64'(fv_cyc - fall_cyc),
        64'(SYNC_LAT + 2));
    chk({tag, "_busy_lo"}, 64'(bus.busy), 64'd0);
    chk({tag, "_excl"}, 64'(both_cnt), 64'd0);
  endtask

  initial begin
    int to0, fv0, d, n;
    logic [39:0] f, fr0;
    logic cr0;
    logic [7:0] b [5];
    bus.start_read = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_frame", 64'(bus.frame), 64'd0);
    chk("rst_crc", 64'(bus.crc_ok), 64'd0);
    chk("rst_fv", 64'(bus.frame_valid), 64'd0);
    chk("rst_to", 64'(bus.timeout_err), 64'd0);
    chk("rst_line", 64'(dht), 64'd1);
    arstn = 1'b1;
    repeat (3) tick();

    build_widths(40'h019000F586, 1'b1);
    txn(0, "good");
    chk("good_exact", 64'(bus.frame), 64'h019000F586);
    build_widths(40'h019000F587, 1'b1);
    txn(0, "badcrc");
    chk("badcrc_crc0", 64'(bus.crc_ok), 64'd0);

    fr0 = bus.frame;
    cr0 = bus.crc_ok;
    to0 = to_cnt;
    fv0 = fv_cnt;
    bus.start_read = 1'b1;
    tick();
    bus.start_read = 1'b0;
    sensor(1'b0, 0, 0);
    n = 0;
    while (to_cnt == to0 && n < 400) begin
      tick();
      n++;
    end
    d = to_cyc - rel_cyc;
    chk("to_seen", 64'(to_cnt - to0), 64'd1);
    chk("to_delay_ok", 64'(d >= 200 && d <= 202 + SYNC_LAT), 64'd1);
    chk("to_frame_kept", 64'(bus.frame), 64'(fr0));
    chk("to_crc_kept", 64'(bus.crc_ok), 64'(cr0));
    chk("to_no_fv", 64'(fv_cnt - fv0), 64'd0);
    chk("to_busy", 64'(bus.busy), 64'd0);
    repeat (5) tick();

    build_widths(40'h019000F586, 1'b1);
    hi_w[0] = 49;
    hi_w[1] = 50;
    hi_w[39] = 49;
    hi_w[38] = 50;
    txn(0, "thresh");

    f = {$urandom, $urandom};
    build_widths(f, 1'b0);
    sensor_inj_start();

    f = {$urandom, $urandom};
    build_widths(f, 1'b0);
    txn(2, "inj_bit10");

    f = {$urandom, $urandom};
    build_widths(f, 1'b0);
    txn(3, "same_cyc");

    bus.start_read = 1'b1;
    tick();
    bus.start_read = 1'b0;
    sensor(1'b1, 0, 2);
    repeat (10) tick();
    chk("post_rst20_idle", 64'(bus.busy), 64'd0);
    f = {$urandom, $urandom};
    build_widths(f, 1'b0);
    txn(0, "after_rst");

    bus.start_read = 1'b1;
    tick();
    bus.start_read = 1'b0;
    sensor(1'b1, 0, 1);
    repeat (10) tick();

    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) b[j] = 8'($urandom);
      b[4] = b[0] + b[1] + b[2] + b[3];
      if ($urandom_range(1, 0) == 1) b[4] = 8'($urandom);
      build_widths({b[0], b[1], b[2], b[3], b[4]}, 1'b0);
      txn(0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  task automatic sensor_inj_start();
    txn(1, "inj_start");
  endtask

endmodule
